// File: rtl/resize_pkg.sv
// Stream geometry and word layout shared by the resize stage and its downstream packer.
package resize_pkg;

  localparam int unsigned PixW      = 8;
  localparam int unsigned DataWidth = 32;
  localparam int unsigned Pack      = DataWidth / PixW;

  typedef struct packed {
    logic [DataWidth-1:0] data;
    logic [Pack-1:0]      keep;
    logic                 last;
    logic                 user;
  } out_word_t;

endpackage

// File: rtl/stream_skid_fifo2.sv
// Two-entry valid/ready FIFO; push and pop in the same cycle keep the count and the ordering.
module stream_skid_fifo2 #(
  parameter int unsigned Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  output logic             full_o,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             pop_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       count_q;
  logic [1:0]       count_d;

  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == 2'd2);
  assign pop_o   = valid_o && ready_i;
  assign data_o  = mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_i, pop_o})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // The caller never pushes into a full FIFO without a simultaneous pop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_o) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/resize_stream_packer.sv
// Packs resized pixels little-endian into wide words, tagging line end and frame start,
// with a 2-entry output FIFO so that upstream backpressure does not depend on a deep path.
module resize_stream_packer
  import resize_pkg::*;
#(
  parameter int unsigned PIX_W     = PixW,
  parameter int unsigned DATAWIDTH = DataWidth,
  parameter int unsigned OUT_W     = 320,
  parameter int unsigned OUT_H     = 240
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_tvalid,
  output logic                       s_tready,
  input  logic [PIX_W-1:0]           s_tdata,
  output logic                       m_tvalid,
  input  logic                       m_tready,
  output logic [DATAWIDTH-1:0]       m_tdata,
  output logic [DATAWIDTH/PIX_W-1:0] m_tkeep,
  output logic                       m_tlast,
  output logic                       m_tuser,
  output logic                       frame_done
);

  localparam int unsigned PACK  = DATAWIDTH / PIX_W;
  localparam int unsigned LaneW = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int unsigned ColW  = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int unsigned RowW  = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [LaneW-1:0] LaneLast = LaneW'(PACK - 1);
  localparam logic [ColW-1:0]  ColLast  = ColW'(OUT_W - 1);
  localparam logic [RowW-1:0]  RowLast  = RowW'(OUT_H - 1);

  typedef struct packed {
    logic [DATAWIDTH-1:0] data;
    logic [PACK-1:0]      keep;
    logic                 last;
    logic                 user;
    logic                 frame_end;
  } fifo_word_t;

  logic [LaneW-1:0]     lane_q, lane_d;
  logic [ColW-1:0]      col_q, col_d;
  logic [RowW-1:0]      row_q, row_d;
  logic [DATAWIDTH-1:0] pack_q, pack_d;
  logic [PACK-1:0]      keep_q, keep_d;

  logic                 accept;
  logic                 commit;
  logic                 line_end;
  logic                 fifo_full;
  logic                 fifo_valid;
  logic                 fifo_pop;
  logic [DATAWIDTH-1:0] word_data;
  logic [PACK-1:0]      word_keep;
  fifo_word_t           push_word;
  fifo_word_t           head_word;

  assign s_tready = !rst && (!fifo_full || m_tready);
  assign accept   = s_tvalid && s_tready;
  assign line_end = (col_q == ColLast);
  assign commit   = accept && ((lane_q == LaneLast) || line_end);

  // Current pack register with the incoming pixel merged into its lane.
  always_comb begin
    word_data = pack_q;
    word_keep = keep_q;
    for (int unsigned k = 0; k < PACK; k++) begin
      if (lane_q == LaneW'(k)) begin
        word_data[k*PIX_W +: PIX_W] = s_tdata;
        word_keep[k]                = 1'b1;
      end
    end
  end

  // Lines start word-aligned, so the first word of a row covers columns 0..PACK-1.
  always_comb begin
    push_word.data      = word_data;
    push_word.keep      = word_keep;
    push_word.last      = line_end;
    push_word.user      = (row_q == '0) && (32'(col_q) < PACK);
    push_word.frame_end = line_end && (row_q == RowLast);
  end

  always_comb begin
    lane_d = lane_q;
    col_d  = col_q;
    row_d  = row_q;
    pack_d = pack_q;
    keep_d = keep_q;
    if (accept) begin
      if (commit) begin
        lane_d = '0;
        pack_d = '0;
        keep_d = '0;
      end else begin
        lane_d = lane_q + 1'b1;
        pack_d = word_data;
        keep_d = word_keep;
      end
      if (line_end) begin
        col_d = '0;
        row_d = (row_q == RowLast) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
      pack_q <= '0;
      keep_q <= '0;
    end else begin
      lane_q <= lane_d;
      col_q  <= col_d;
      row_q  <= row_d;
      pack_q <= pack_d;
      keep_q <= keep_d;
    end
  end

  stream_skid_fifo2 #(
    .Width($bits(fifo_word_t))
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (commit),
    .data_i (push_word),
    .full_o (fifo_full),
    .valid_o(fifo_valid),
    .ready_i(m_tready && !rst),
    .data_o (head_word),
    .pop_o  (fifo_pop)
  );

  assign m_tvalid   = fifo_valid && !rst;
  assign m_tdata    = head_word.data;
  assign m_tkeep    = head_word.keep;
  assign m_tlast    = head_word.last;
  assign m_tuser    = head_word.user;
  assign frame_done = fifo_pop && head_word.frame_end;

endmodule

// File: tb/tb_resize_stream_packer.sv
// Directed bench for resize_stream_packer: 6x2 frame geometry plus an 8-wide instance.
module tb_resize_stream_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s_tvalid, s_tready, m_tvalid, m_tready, m_tlast, m_tuser, frame_done;
  logic [7:0]  s_tdata;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        s8_tvalid, s8_tready, m8_tvalid, m8_tready, m8_tlast, m8_tuser, frame8_done;
  logic [7:0]  s8_tdata;
  logic [31:0] m8_tdata;
  logic [3:0]  m8_tkeep;

  resize_stream_packer #(.PIX_W(8), .DATAWIDTH(32), .OUT_W(6), .OUT_H(2)) dut (
    .clk(clk), .rst(rst), .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tkeep(m_tkeep),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .frame_done(frame_done)
  );

  resize_stream_packer #(.PIX_W(8), .DATAWIDTH(32), .OUT_W(8), .OUT_H(2)) dut8 (
    .clk(clk), .rst(rst), .s_tvalid(s8_tvalid), .s_tready(s8_tready), .s_tdata(s8_tdata),
    .m_tvalid(m8_tvalid), .m_tready(m8_tready), .m_tdata(m8_tdata), .m_tkeep(m8_tkeep),
    .m_tlast(m8_tlast), .m_tuser(m8_tuser), .frame_done(frame8_done)
  );

  typedef struct {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
    logic        u;
    int          c;
  } pop_t;

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   acc_q[$];
  int   fd_q[$];
  pop_t pop_q[$];
  pop_t pop8_q[$];
  int   acc8_n = 0;
  pop_t mon_p;

  // Handshake log, sampled on the falling edge while inputs are stable.
  always @(negedge clk) begin
    cyc++;
    if (s_tvalid && s_tready) acc_q.push_back(cyc);
    if (frame_done) fd_q.push_back(cyc);
    if (m_tvalid && m_tready) begin
      mon_p.d = m_tdata; mon_p.k = m_tkeep; mon_p.l = m_tlast; mon_p.u = m_tuser; mon_p.c = cyc;
      pop_q.push_back(mon_p);
    end
    if (s8_tvalid && s8_tready) acc8_n++;
    if (m8_tvalid && m8_tready) begin
      mon_p.d = m8_tdata; mon_p.k = m8_tkeep; mon_p.l = m8_tlast; mon_p.u = m8_tuser;
      mon_p.c = cyc;
      pop8_q.push_back(mon_p);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  function automatic pop_t get_pop(input bit wide8, input int i);
    pop_t p;
    p.d = 'x; p.k = 'x; p.l = 1'bx; p.u = 1'bx; p.c = -1;
    if (!wide8 && i < pop_q.size()) p = pop_q[i];
    if (wide8 && i < pop8_q.size()) p = pop8_q[i];
    return p;
  endfunction

  function automatic int acc_at(input int i);
    return (i < acc_q.size()) ? acc_q[i] : -100;
  endfunction

  task automatic clear_logs();
    acc_q.delete(); fd_q.delete(); pop_q.delete(); pop8_q.delete(); acc8_n = 0;
  endtask

  task automatic idle_inputs();
    s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = 8'h00;
    s8_tvalid = 1'b0; m8_tready = 1'b0; s8_tdata = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drive_seq(input logic [7:0] first, input int n, input bit rnd, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (acc_q.size() >= n) break;
      s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      s_tdata  = first + 8'(acc_q.size());
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic drain(input int n_cycles);
    for (int i = 0; i < n_cycles; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b0;
      m_tready = 1'b1;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (s_tready !== 1'b0) $display("FAIL rst_s_tready got=%b exp=0", s_tready); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (s_tready !== 1'b1) $display("FAIL post_rst_s_tready got=%b exp=1", s_tready); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b0) $display("FAIL post_rst_m_tvalid got=%b exp=0", m_tvalid); else n_pass++;
    n_checks++; if (m_tdata !== 32'h0) $display("FAIL post_rst_m_tdata got=%h exp=0", m_tdata); else n_pass++;
    n_checks++;
    if ({m_tkeep, m_tlast, m_tuser, frame_done} !== 7'h0)
      $display("FAIL post_rst_flags got=%h exp=0", {m_tkeep, m_tlast, m_tuser, frame_done});
    else n_pass++;
    clear_logs();
  endtask

  task automatic test_line();
    pop_t w0, w1;
    do_reset();
    drive_seq(8'h01, 6, 1'b0, 20);
    drain(4);
    w0 = get_pop(1'b0, 0); w1 = get_pop(1'b0, 1);
    n_checks++; if (pop_q.size() != 2) $display("FAIL line_words got=%0d exp=2", pop_q.size()); else n_pass++;
    n_checks++; if (w0.d !== 32'h04030201) $display("FAIL line_w0_data got=%h exp=04030201", w0.d); else n_pass++;
    n_checks++;
    if ({w0.k, w0.u, w0.l} !== {4'hF, 1'b1, 1'b0})
      $display("FAIL line_w0_keep_user_last got=%h/%b/%b exp=f/1/0", w0.k, w0.u, w0.l);
    else n_pass++;
    n_checks++; if (w1.d !== 32'h00000605) $display("FAIL line_w1_data got=%h exp=00000605", w1.d); else n_pass++;
    n_checks++;
    if ({w1.k, w1.u, w1.l} !== {4'h3, 1'b0, 1'b1})
      $display("FAIL line_w1_keep_user_last got=%h/%b/%b exp=3/0/1", w1.k, w1.u, w1.l);
    else n_pass++;
    n_checks++;
    if (w0.c != acc_at(3) + 1) $display("FAIL line_w0_latency got=%0d exp=%0d", w0.c, acc_at(3) + 1);
    else n_pass++;
    n_checks++;
    if (w1.c != acc_at(5) + 1) $display("FAIL line_w1_latency got=%0d exp=%0d", w1.c, acc_at(5) + 1);
    else n_pass++;
    n_checks++; if (fd_q.size() != 0) $display("FAIL line_no_frame_done got=%0d exp=0", fd_q.size()); else n_pass++;
  endtask

  task automatic test_frame();
    pop_t w2, w3;
    do_reset();
    drive_seq(8'h01, 12, 1'b0, 40);
    drain(4);
    w2 = get_pop(1'b0, 2); w3 = get_pop(1'b0, 3);
    n_checks++; if (pop_q.size() != 4) $display("FAIL frame_words got=%0d exp=4", pop_q.size()); else n_pass++;
    n_checks++;
    if ({w2.d, w2.u, w2.l} !== {32'h0A090807, 1'b0, 1'b0})
      $display("FAIL frame_w2 got=%h/%b/%b exp=0a090807/0/0", w2.d, w2.u, w2.l);
    else n_pass++;
    n_checks++;
    if ({w3.d, w3.k, w3.u, w3.l} !== {32'h00000C0B, 4'h3, 1'b0, 1'b1})
      $display("FAIL frame_w3 got=%h/%h/%b/%b exp=00000c0b/3/0/1", w3.d, w3.k, w3.u, w3.l);
    else n_pass++;
    n_checks++; if (fd_q.size() != 1) $display("FAIL frame_done_count got=%0d exp=1", fd_q.size()); else n_pass++;
    n_checks++;
    if (fd_q.size() != 1 || fd_q[0] != w3.c)
      $display("FAIL frame_done_cycle got=%0d exp=%0d", (fd_q.size() > 0) ? fd_q[0] : -1, w3.c);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int   unstable = 0;
    pop_t w0, w1;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      s_tvalid = 1'b1;
      s_tdata  = 8'h01 + 8'(acc_q.size());
      m_tready = 1'b0;
      @(negedge clk);
      if (m_tvalid && (m_tdata !== 32'h04030201 || m_tkeep !== 4'hF || m_tuser !== 1'b1)) unstable++;
    end
    n_checks++; if (acc_q.size() != 6) $display("FAIL bp_accepted got=%0d exp=6", acc_q.size()); else n_pass++;
    n_checks++; if (s_tready !== 1'b0) $display("FAIL bp_s_tready_full got=%b exp=0", s_tready); else n_pass++;
    n_checks++; if (m_tvalid !== 1'b1) $display("FAIL bp_m_tvalid got=%b exp=1", m_tvalid); else n_pass++;
    n_checks++; if (unstable != 0) $display("FAIL bp_head_stable got=%0d exp=0", unstable); else n_pass++;
    n_checks++; if (pop_q.size() != 0) $display("FAIL bp_no_pop got=%0d exp=0", pop_q.size()); else n_pass++;
    drain(4);
    w0 = get_pop(1'b0, 0); w1 = get_pop(1'b0, 1);
    n_checks++; if (pop_q.size() != 2) $display("FAIL bp_drain_words got=%0d exp=2", pop_q.size()); else n_pass++;
    n_checks++;
    if ({w0.d, w1.d} !== {32'h04030201, 32'h00000605})
      $display("FAIL bp_drain_order got=%h,%h exp=04030201,00000605", w0.d, w1.d);
    else n_pass++;
    n_checks++; if (s_tready !== 1'b1) $display("FAIL bp_s_tready_after got=%b exp=1", s_tready); else n_pass++;
  endtask

  task automatic test_random();
    int          bad = 0;
    int          users = 0;
    int          idx;
    logic [31:0] exp_d;
    logic [3:0]  exp_k;
    pop_t        p;
    do_reset();
    drive_seq(8'h01, 36, 1'b1, 1500);
    for (int i = 0; i < 1500 && pop_q.size() < 12; i++) begin
      @(posedge clk); #1;
      m_tready = 1'($urandom_range(0, 1));
    end
    drain(2);
    n_checks++; if (acc_q.size() != 36) $display("FAIL rnd_accepted got=%0d exp=36", acc_q.size()); else n_pass++;
    n_checks++; if (pop_q.size() != 12) $display("FAIL rnd_words got=%0d exp=12", pop_q.size()); else n_pass++;
    // Expected words from frame geometry: 2 rows of 6 pixels, words of 4 then 2 pixels.
    for (int w = 0; w < 12; w++) begin
      exp_d = '0; exp_k = '0;
      for (int l = 0; l < ((w % 2 == 1) ? 2 : 4); l++) begin
        idx = (w / 4) * 12 + ((w % 4) / 2) * 6 + (w % 2) * 4 + l;
        exp_d[l*8 +: 8] = 8'(idx + 1);
        exp_k[l] = 1'b1;
      end
      p = get_pop(1'b0, w);
      if (p.u === 1'b1) users++;
      n_checks++;
      if ({p.d, p.k, p.l, p.u} !== {exp_d, exp_k, (w % 2 == 1), (w % 4 == 0)}) begin
        bad++;
        $display("FAIL rnd_word%0d got=%h/%h/%b/%b exp=%h/%h/%b/%b", w, p.d, p.k, p.l, p.u,
                 exp_d, exp_k, (w % 2 == 1), (w % 4 == 0));
      end else n_pass++;
    end
    n_checks++; if (users != 3) $display("FAIL rnd_tuser_count got=%0d exp=3", users); else n_pass++;
    n_checks++; if (fd_q.size() != 3) $display("FAIL rnd_frame_done got=%0d exp=3", fd_q.size()); else n_pass++;
  endtask

  task automatic test_mid_reset();
    pop_t w0;
    do_reset();
    drive_seq(8'h11, 3, 1'b0, 10);
    drain(2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    drain(2);
    n_checks++; if (pop_q.size() != 0) $display("FAIL mrst_no_partial got=%0d exp=0", pop_q.size()); else n_pass++;
    clear_logs();
    drive_seq(8'hA1, 4, 1'b0, 10);
    drain(3);
    w0 = get_pop(1'b0, 0);
    n_checks++; if (pop_q.size() != 1) $display("FAIL mrst_words got=%0d exp=1", pop_q.size()); else n_pass++;
    n_checks++;
    if ({w0.d, w0.k, w0.u, w0.l} !== {32'hA4A3A2A1, 4'hF, 1'b1, 1'b0})
      $display("FAIL mrst_word got=%h/%h/%b/%b exp=a4a3a2a1/f/1/0", w0.d, w0.k, w0.u, w0.l);
    else n_pass++;
  endtask

  task automatic test_width8();
    pop_t w0, w1;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (acc8_n >= 8) break;
      s8_tvalid = 1'b1;
      s8_tdata  = 8'h21 + 8'(acc8_n);
      m8_tready = 1'b1;
    end
    s8_tvalid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    w0 = get_pop(1'b1, 0); w1 = get_pop(1'b1, 1);
    n_checks++; if (pop8_q.size() != 2) $display("FAIL w8_words got=%0d exp=2", pop8_q.size()); else n_pass++;
    n_checks++;
    if ({w0.d, w0.k, w0.u, w0.l} !== {32'h24232221, 4'hF, 1'b1, 1'b0})
      $display("FAIL w8_w0 got=%h/%h/%b/%b exp=24232221/f/1/0", w0.d, w0.k, w0.u, w0.l);
    else n_pass++;
    n_checks++;
    if ({w1.d, w1.k, w1.u, w1.l} !== {32'h28272625, 4'hF, 1'b0, 1'b1})
      $display("FAIL w8_w1 got=%h/%h/%b/%b exp=28272625/f/0/1", w1.d, w1.k, w1.u, w1.l);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_backpressure();
    test_random();
    test_mid_reset();
    test_width8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
